// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the MIPS multiply/divide unit: operation codes, FSM states
// and small op-classification helpers used by the control decode.
package mips_cpu_muldiv_pkg;

   // Operation codes driven on op. Codes 6 and 7 complete as no-ops.
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_NOP6  = 3'd6,
      OP_NOP7  = 3'd7
   } muldiv_op_t;

   // Control FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_WB   = 2'd3
   } muldiv_state_t;

   localparam int MULDIV_DEFAULT_WIDTH = 32;

   // Signed variants take absolute values first and fix the sign in WB.
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic is_mul_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Request/response bundle between the execute-stage control and the
// multiply/divide unit.
//
// Handshake: start is sampled on the rising clock edge and is accepted only
// while busy is low; op/a/b are captured at that edge and need not be held.
// busy stays high while an iterative operation runs, during which start is
// ignored. done pulses for one cycle after hi/lo were written, and a new
// start may be presented in that same cycle. state is a debug view of the FSM.
interface mips_cpu_muldiv_if #(
   parameter int WIDTH = 32
);
   import mips_cpu_muldiv_pkg::*;

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   muldiv_state_t    state;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, state
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, state
   );

endinterface

// File: rtl/mips_cpu_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it did not
// borrow. The dividend is held in the quotient register and shifts out MSB
// first while quotient bits shift in at the bottom.
module mips_cpu_divider_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Trial subtraction; the partial remainder is always below the divisor,
   // so the top bit of diff is a clean borrow flag.
   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      if (!diff[WIDTH]) begin
         rem_out = diff[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b1};
      end else begin
         rem_out = shifted[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO registers.
// Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO; codes 6/7 complete as no-ops.
// Multiply is shift-add and divide is restoring, one bit per cycle each.
// Signed operations run on magnitudes and get their signs fixed in WB.
// Optional build macro MULDIV_FAST_MUL_EN: products come from a single
// multiplier and complete one cycle after acceptance.
module mips_cpu_muldiv
   import mips_cpu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   mips_cpu_muldiv_if.slave  bus
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   muldiv_state_t      state;
   muldiv_state_t      state_nx;
   logic [CW-1:0]      cnt;

   // acc is the {remainder, quotient} pair in DIV and the running product in
   // MUL; opnd is the divisor or the multiplicand magnitude.
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   a_raw;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               neg_q;
   logic               neg_r;
   logic               is_div;
   logic               div0;
   logic               done_q;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nx;
   logic [WIDTH-1:0]   rem_nx;
   logic [WIDTH-1:0]   quo_nx;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Operand magnitudes for the request currently on the bus.
   always_comb begin
      a_neg = is_signed_op(bus.op) & bus.a[WIDTH-1];
      b_neg = is_signed_op(bus.op) & bus.b[WIDTH-1];
      abs_a = a_neg ? -bus.a : bus.a;
      abs_b = b_neg ? -bus.b : bus.b;
   end

   // Shift-add step: conditionally add the multiplicand into the upper half,
   // then shift the whole product right, consuming one multiplier bit.
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_nx  = {mul_sum, acc[WIDTH-1:1]};
   end

   mips_cpu_divider_step #(
      .WIDTH (WIDTH)
   ) u_div_step (
      .rem_in  (acc[2*WIDTH-1:WIDTH]),
      .quo_in  (acc[WIDTH-1:0]),
      .divisor (opnd),
      .rem_out (rem_nx),
      .quo_out (quo_nx)
   );

   // Sign correction applied at write-back.
   always_comb begin
      prod_fix = neg_q ? -acc : acc;
      quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next-state: divide by zero and the fast multiplier skip straight to WB.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               if (is_mul_op(bus.op)) begin
`ifdef MULDIV_FAST_MUL_EN
                  state_nx = ST_WB;
`else
                  state_nx = ST_MUL;
`endif
               end else if (is_div_op(bus.op)) begin
                  state_nx = (bus.b == '0) ? ST_WB : ST_DIV;
               end
            end
         end
         ST_MUL:  if (cnt == CNT_ONE) state_nx = ST_WB;
         ST_DIV:  if (cnt == CNT_ONE) state_nx = ST_WB;
         ST_WB:   state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // FSM outputs and register views.
   always_comb begin
      bus.busy  = (state != ST_IDLE);
      bus.done  = done_q;
      bus.hi    = hi_q;
      bus.lo    = lo_q;
      bus.state = state;
   end

   // Datapath: operand capture, iteration, and the HI/LO write points.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         a_raw  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         is_div <= 1'b0;
         div0   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  a_raw  <= bus.a;
                  is_div <= 1'b0;
                  div0   <= 1'b0;
                  neg_q  <= 1'b0;
                  neg_r  <= 1'b0;
                  if (is_mul_op(bus.op)) begin
                     neg_q <= a_neg ^ b_neg;
                     opnd  <= abs_a;
                     cnt   <= CNT_INIT;
`ifdef MULDIV_FAST_MUL_EN
                     acc   <= {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`else
                     acc   <= {{WIDTH{1'b0}}, abs_b};
`endif
                  end else if (is_div_op(bus.op)) begin
                     is_div <= 1'b1;
                     div0   <= (bus.b == '0);
                     neg_q  <= a_neg ^ b_neg;
                     neg_r  <= a_neg;
                     opnd   <= abs_b;
                     acc    <= {{WIDTH{1'b0}}, abs_a};
                     cnt    <= CNT_INIT;
                  end else if (bus.op == OP_MTHI) begin
                     hi_q   <= bus.a;
                     done_q <= 1'b1;
                  end else if (bus.op == OP_MTLO) begin
                     lo_q   <= bus.a;
                     done_q <= 1'b1;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               acc <= mul_nx;
               cnt <= cnt - CNT_ONE;
            end
            ST_DIV: begin
               acc <= {rem_nx, quo_nx};
               cnt <= cnt - CNT_ONE;
            end
            ST_WB: begin
               done_q <= 1'b1;
               if (div0) begin
                  lo_q <= '1;
                  hi_q <= a_raw;
               end else if (is_div) begin
                  lo_q <= quo_fix;
                  hi_q <= rem_fix;
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS CPU. It sits beside the combinational ALU in the execute stage and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes HI/LO continuously for MFHI/MFLO. Datapath width is parametrised, multiplication and division are iterative, and a start/busy/done handshake lets the control unit stall.

## Interface
- `WIDTH`, default 32: operand, HI and LO width. Must be at least 4.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: request an operation. Sampled on the rising edge of `clk`.
- `op` input, 3 bits: operation code, see package.
- `a` input, WIDTH bits: rs operand (multiplicand, dividend, or MTHI/MTLO data).
- `b` input, WIDTH bits: rt operand (multiplier or divisor).
- `busy` output, 1 bit: operation in progress.
- `done` output, 1 bit: one-cycle pulse when HI/LO have just been written.
- `hi` output, WIDTH bits: HI register.
- `lo` output, WIDTH bits: LO register.

## Operation
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO. Codes 6 and 7 are accepted as no-ops: `done` pulses and HI/LO are unchanged.
- FSM states:
  - IDLE
  - MUL: shift-add, one multiplier bit per cycle
  - DIV: restoring, one quotient bit per cycle
  - WB: sign fix-up and HI/LO write
- `start` is accepted only in IDLE. While `busy` is high, `start` is ignored and the operands are not re-sampled.
- `a`, `b` and `op` are captured at the accepting edge. They need not be held afterwards.
- Signed ops take absolute values, run unsigned, then apply sign correction in WB:
  - product sign = sign(a) XOR sign(b)
  - quotient sign = sign(a) XOR sign(b)
  - remainder sign = sign(a)
- MULT/MULTU write {hi, lo} = the full 2*WIDTH-bit product.
- DIV/DIVU write lo = quotient and hi = remainder.
- Signed overflow: most-negative / -1 gives lo = most-negative and hi = 0.
- Divide by zero, any signedness: lo = all ones, hi = a. Completes via the fast path described under Timing.
- MTHI writes hi = a. MTLO writes lo = a. The other register is unchanged.
- An iteration counter of width $clog2(WIDTH+1) counts down from WIDTH in MUL/DIV.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, state = IDLE, counter = 0.
- Let E0 be the edge at which `start` is accepted.
- MTHI/MTLO/no-op: register written at E0. `done` is high in the cycle after E0. `busy` never rises.
- Iterative MUL/DIV:
  - `busy` is high from after E0 through the cycle ending at edge E(WIDTH+1).
  - Iterations occur at E1..E(WIDTH).
  - WB writes HI/LO at E(WIDTH+1).
  - `done` is high in the cycle after E(WIDTH+1), with `busy` low in that same cycle.
- Divide by zero: WB at E1, so `busy` is high for exactly one cycle.
- A new `start` in the `done` cycle is accepted; back-to-back operation is legal.
- HI/LO change only at write edges. Intermediate values are never visible on `hi`/`lo`.
- Reset asserted mid-operation aborts immediately:
  - outputs return to reset values
  - no `done` pulse
  - no partial write

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MULT/MULTU compute the product with a single `*` operator.
  - Enter WB directly, writing at E1.
  - `busy` is high for one cycle; `done` is high in the cycle after E1.
- Not defined: MUL uses the WIDTH-cycle shift-add path.
- Division is always iterative.

## Structure
- Package `mips_cpu_muldiv_pkg` holds:
  - the `muldiv_op_t` enum (3-bit, codes above)
  - the `muldiv_state_t` enum (IDLE, MUL, DIV, WB)
  - shared by the control decoder and testbench.
- Sub-module `mips_cpu_divider_step` is combinational: one restoring-division step.
  - Inputs: remainder, quotient, divisor.
  - Outputs: next remainder and quotient.
  - Instantiated once and reused each DIV cycle.
- The top level owns the FSM, counter, operand and sign registers, and HI/LO.

## Test plan
All scenarios use WIDTH = 32.

- MULT a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE. Check `done` timing with and without `MULDIV_FAST_MUL_EN` (after E33 vs after E1).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. `busy` is high for 33 cycles.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIV or DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, `done` after E1.
- MTLO a=0x00001234 -> lo=0x00001234 after E0, `done` for one cycle, `busy` stays 0, hi unchanged.
- During DIVU, pulse `start` with MTHI a=0xDEADBEEF -> ignored: hi ends as the remainder and exactly one `done` pulse occurs. Then issue `start` in the `done` cycle -> accepted.
- Assert `reset` at cycle 10 of a DIV -> hi=lo=0 and `busy`=0 immediately, no `done` pulse. A subsequent DIVU 9/3 -> lo=3, hi=0.
